// File: rtl/wb_spi_master_mc.sv
// rtl/wb_spi_master_mc.sv - 8-bit Wishbone SPI master with TX/RX FIFOs, chip selects, CPOL/CPHA modes and SCK divider
module wb_spi_master_mc #(
  parameter int         NCS        = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RST    = 8'h03
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cyc_i,
  input  logic           stb_i,
  input  logic [2:0]     adr_i,
  input  logic           we_i,
  input  logic [7:0]     dat_i,
  output logic [7:0]     dat_o,
  output logic           ack_o,
  output logic           inta_o,
  output logic           sck_o,
  output logic           mosi_o,
  input  logic           miso_i,
  output logic [NCS-1:0] ss_o
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t         state;
  logic           en, cpol, cpha, ie;
  logic [7:0]     div;
  logic [NCS-1:0] cs;
  logic           rxovf, txovf;

  logic [2:0]     acc_adr;
  logic           acc_we, acc_pop;
  logic [7:0]     acc_dat;
  logic           wb_req;

  logic [7:0]     tx_mem [FIFO_DEPTH];
  logic [7:0]     rx_mem [FIFO_DEPTH];
  logic [AW:0]    tx_wp, tx_rp, rx_wp, rx_rp;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic           tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic           rx_push_req, rx_push, rx_pop, rx_ovf_set;
  logic           stat_w1c, busy;

  logic [7:0]     shreg;
  logic           rx_bit;
  logic           cpol_l, cpha_l;
  logic [7:0]     div_l, hcnt;
  logic [3:0]     ecnt;

  logic [7:0]     stat, cs_rd, rd_mux;

  assign ss_o     = ~cs;
  assign busy     = (state != S_IDLE);
  assign wb_req   = cyc_i & stb_i & ~ack_o;

  // Extra MSB on each pointer separates full from empty when the indices match
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign tx_pop      = (state == S_LOAD);
  assign tx_push_req = ack_o & acc_we & (acc_adr == 3'd2);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;

  assign rx_pop      = ack_o & acc_pop;
  assign rx_push_req = (state == S_DONE);
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop;

  assign stat_w1c = ack_o & acc_we & (acc_adr == 3'd1);
  assign stat     = {1'b0, txovf, rxovf, busy, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    cs_rd = 8'h00;
    cs_rd[NCS-1:0] = cs;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (adr_i)
      3'd0: rd_mux = {4'b0000, ie, cpha, cpol, en};
      3'd1: rd_mux = stat;
      3'd2: if (!rx_empty) rd_mux = rx_mem[rx_rp[AW-1:0]];
      3'd3: rd_mux = div;
      3'd4: rd_mux = cs_rd;
      default: rd_mux = 8'h00;
    endcase
  end

  // Read data is captured on the request cycle; side effects wait for the ack cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o   <= 1'b0;
      dat_o   <= 8'h00;
      acc_adr <= 3'd0;
      acc_we  <= 1'b0;
      acc_dat <= 8'h00;
      acc_pop <= 1'b0;
      en      <= 1'b0;
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      ie      <= 1'b0;
      div     <= DIV_RST;
      cs      <= '0;
      rxovf   <= 1'b0;
      txovf   <= 1'b0;
      inta_o  <= 1'b0;
    end else begin
      ack_o <= wb_req;
      dat_o <= wb_req ? rd_mux : 8'h00;
      if (wb_req) begin
        acc_adr <= adr_i;
        acc_we  <= we_i;
        acc_dat <= dat_i;
        acc_pop <= ~we_i & (adr_i == 3'd2) & ~rx_empty;
      end
      if (ack_o && acc_we) begin
        case (acc_adr)
          3'd0: {ie, cpha, cpol, en} <= acc_dat[3:0];
          3'd3: div <= acc_dat;
          3'd4: cs  <= acc_dat[NCS-1:0];
          default: ;
        endcase
      end
      rxovf  <= rx_ovf_set | (rxovf & ~(stat_w1c & acc_dat[5]));
      txovf  <= tx_ovf_set | (txovf & ~(stat_w1c & acc_dat[6]));
      inta_o <= ie & (~rx_empty | rxovf | txovf);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= acc_dat;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= shreg;
  end

  // ecnt counts the 16 SCK edges of a byte; even counts are leading edges
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      sck_o  <= 1'b0;
      mosi_o <= 1'b0;
      shreg  <= 8'h00;
      rx_bit <= 1'b0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      div_l  <= 8'h00;
      hcnt   <= 8'h00;
      ecnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          sck_o <= cpol;
          if (en && !tx_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          shreg  <= tx_mem[tx_rp[AW-1:0]];
          cpol_l <= cpol;
          cpha_l <= cpha;
          div_l  <= div;
          hcnt   <= 8'h00;
          ecnt   <= 4'd0;
          sck_o  <= cpol;
          if (!cpha) mosi_o <= tx_mem[tx_rp[AW-1:0]][7];
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (hcnt == div_l) begin
            hcnt  <= 8'h00;
            sck_o <= ~sck_o;
            ecnt  <= ecnt + 4'd1;
            if (!ecnt[0]) begin
              if (!cpha_l) rx_bit <= miso_i;
              else         mosi_o <= shreg[7];
            end else begin
              if (!cpha_l) begin
                shreg  <= {shreg[6:0], rx_bit};
                mosi_o <= shreg[6];
              end else begin
                shreg  <= {shreg[6:0], miso_i};
              end
            end
            if (ecnt == 4'd15) state <= S_DONE;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        S_DONE: begin
          sck_o <= cpol_l;
          if (en && !tx_empty) state <= S_LOAD;
          else                 state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_master_mc.sv
// tb/tb_wb_spi_master_mc.sv - self-checking bench for wb_spi_master_mc
module tb_wb_spi_master_mc;

  localparam int NCS = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cyc, stb, we;
  logic [2:0]     adr;
  logic [7:0]     dat_w;
  logic [7:0]     dat_o;
  logic           ack_o, inta_o, sck_o, mosi_o, miso;
  logic [NCS-1:0] ss_o;

  wb_spi_master_mc #(.NCS(NCS), .FIFO_DEPTH(4), .DIV_RST(8'h03)) dut (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .we_i(we),
    .dat_i(dat_w), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o), .sck_o(sck_o),
    .mosi_o(mosi_o), .miso_i(miso), .ss_o(ss_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc_cnt = 0;
  int ack_time;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI slave model on chip select 0
  bit         loop = 1'b0;
  bit         slv_en = 1'b0;
  bit         s_cpol, s_cpha;
  logic [7:0] slv_tx, slv_rx, slv_cap, slv_resp;
  int         slv_cnt;
  assign miso = loop ? mosi_o : slv_tx[7];

  always @(sck_o) begin
    if (slv_en && !ss_o[0]) begin
      if (sck_o != s_cpol) begin
        if (!s_cpha) slv_rx = {slv_rx[6:0], mosi_o};
      end else begin
        if (s_cpha) slv_rx = {slv_rx[6:0], mosi_o};
        slv_cnt++;
        if (slv_cnt == 8) begin
          slv_cap = slv_rx;
          slv_cnt = 0;
          slv_tx  = slv_resp;
        end else begin
          slv_tx = {slv_tx[6:0], 1'b0};
        end
      end
    end
  end

  // SCK pulse-width scoreboard: expected active-phase lengths in clk cycles
  bit mon_en = 1'b0;
  bit cpol_tb = 1'b0;
  int hi = 0;
  int pq[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (sck_o !== cpol_tb) hi++;
      else if (hi > 0) begin
        if (pq.size() == 0) chk("sck_extra_pulse", hi, 0);
        else chk("sck_half_period", hi, pq.pop_front());
        hi = 0;
      end
    end
  end

  logic [7:0] rx_q[$];

  task automatic wb(input logic [2:0] a, input logic w, input logic [7:0] d, output logic [7:0] r);
    bit got = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_w = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_o) begin got = 1'b1; break; end
    end
    r = dat_o;
    ack_time = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) chk("wb_ack_timeout", got, 1);
    @(negedge clk);
    chk("ack_single_cycle", ack_o, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r;
    wb(a, 1'b1, d, r);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] e, input string n);
    logic [7:0] r;
    wb(a, 1'b0, 8'h00, r);
    chk(n, r, e);
  endtask

  task automatic rx_pop_chk(input string n);
    logic [7:0] r;
    wb(3'd2, 1'b0, 8'h00, r);
    if (rx_q.size() == 0) chk({n, "_unexpected"}, r, 8'h00);
    else chk(n, r, rx_q.pop_front());
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wb(3'd1, 1'b0, 8'h00, s);
      if ((s & 8'h11) == 8'h01) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", ok, 1);
  endtask

  typedef struct {
    logic [2:0] adr;
    logic       we;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[21];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int t0;
    bit seen;

    tbl[0]  = '{3'd0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{3'd1, 1'b0, 8'h00, 8'h05};
    tbl[2]  = '{3'd2, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{3'd3, 1'b0, 8'h00, 8'h03};
    tbl[4]  = '{3'd4, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{3'd5, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{3'd6, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{3'd7, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{3'd0, 1'b1, 8'hFF, 8'h00};
    tbl[9]  = '{3'd0, 1'b0, 8'h00, 8'h0F};
    tbl[10] = '{3'd4, 1'b1, 8'hFF, 8'h00};
    tbl[11] = '{3'd4, 1'b0, 8'h00, 8'h0F};
    tbl[12] = '{3'd3, 1'b1, 8'h5A, 8'h00};
    tbl[13] = '{3'd3, 1'b0, 8'h00, 8'h5A};
    tbl[14] = '{3'd6, 1'b1, 8'hFF, 8'h00};
    tbl[15] = '{3'd6, 1'b0, 8'h00, 8'h00};
    tbl[16] = '{3'd1, 1'b1, 8'hFF, 8'h00};
    tbl[17] = '{3'd1, 1'b0, 8'h00, 8'h05};
    tbl[18] = '{3'd0, 1'b1, 8'h00, 8'h00};
    tbl[19] = '{3'd4, 1'b1, 8'h00, 8'h00};
    tbl[20] = '{3'd3, 1'b1, 8'h03, 8'h00};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; dat_w = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck_o, 0);
    chk("rst_mosi", mosi_o, 0);
    chk("rst_ss", ss_o, 4'hF);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_inta", inta_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].we) wr(tbl[i].adr, tbl[i].wdat);
      else begin
        wb(tbl[i].adr, 1'b0, 8'h00, r);
        chk($sformatf("reg_tbl[%0d]", i), r, tbl[i].exp);
      end
    end

    // Mode 0, DIV=0, loopback: latency and SCK timing
    loop = 1'b1; cpol_tb = 1'b0;
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h01);
    chk("ss_sel0", ss_o, 4'hE);
    wr(3'd0, 8'h09);
    for (int i = 0; i < 8; i++) pq.push_back(1);
    mon_en = 1'b1;
    rx_q.push_back(8'hA5);
    wr(3'd2, 8'hA5);
    t0 = ack_time;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inta_o) begin seen = 1'b1; break; end
    end
    chk("inta_seen", seen, 1);
    chk("push_latency", cyc_cnt - t0, 21);
    wait_idle();
    chk("sck_pulse_count", pq.size(), 0);
    mon_en = 1'b0;
    rx_pop_chk("rx_mode0");
    rd_chk(3'd1, 8'h05, "stat_after_mode0");
    wr(3'd0, 8'h00);
    wr(3'd4, 8'h00);

    // Modes 1..3 against the slave model
    loop = 1'b0;
    for (int m = 1; m < 4; m++) begin
      s_cpol = m[1]; s_cpha = m[0];
      wr(3'd0, {5'b0, s_cpha, s_cpol, 1'b0});
      slv_tx = 8'h3C; slv_resp = 8'h3C; slv_cnt = 0; slv_rx = 8'h00; slv_cap = 8'h00;
      slv_en = 1'b1;
      wr(3'd3, 8'h01);
      wr(3'd4, 8'h01);
      rx_q.push_back(8'h3C);
      wr(3'd2, 8'hC3);
      wr(3'd0, {5'b0, s_cpha, s_cpol, 1'b1});
      wait_idle();
      chk($sformatf("slave_cap_mode%0d", m), slv_cap, 8'hC3);
      chk($sformatf("idle_sck_mode%0d", m), sck_o, s_cpol);
      rx_pop_chk($sformatf("rx_mode%0d", m));
      wr(3'd4, 8'h00);
      slv_en = 1'b0;
    end
    wr(3'd0, 8'h00);

    // FIFO boundaries and overflow flags
    loop = 1'b1;
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h01);
    wr(3'd2, 8'h11); wr(3'd2, 8'h22); wr(3'd2, 8'h33); wr(3'd2, 8'h44); wr(3'd2, 8'h55);
    rd_chk(3'd1, 8'h46, "stat_tx_full_ovf");
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    wr(3'd0, 8'h09);
    wait_idle();
    rd_chk(3'd1, 8'h49, "stat_rx_full");
    wr(3'd2, 8'h66);
    wait_idle();
    rd_chk(3'd1, 8'h69, "stat_rx_ovf");
    chk("inta_ovf", inta_o, 1);
    wr(3'd1, 8'h60);
    rd_chk(3'd1, 8'h09, "stat_w1c");
    for (int i = 0; i < 4; i++) rx_pop_chk($sformatf("rx_fifo[%0d]", i));
    rd_chk(3'd2, 8'h00, "rx_empty_read");
    rd_chk(3'd1, 8'h05, "stat_drained");
    chk("inta_cleared", inta_o, 0);
    wr(3'd0, 8'h00);

    // DIV change mid-byte applies to the next byte only
    wr(3'd2, 8'h81);
    wr(3'd2, 8'h7E);
    rx_q.push_back(8'h81); rx_q.push_back(8'h7E);
    for (int i = 0; i < 8; i++) pq.push_back(1);
    for (int i = 0; i < 8; i++) pq.push_back(8);
    hi = 0; mon_en = 1'b1;
    wr(3'd0, 8'h01);
    wr(3'd3, 8'h07);
    wait_idle();
    chk("div_pulse_count", pq.size(), 0);
    mon_en = 1'b0;
    rx_pop_chk("rx_div_b0");
    rx_pop_chk("rx_div_b1");

    // Async reset in the middle of SHIFT
    wr(3'd3, 8'h03);
    wr(3'd0, 8'h03);
    wr(3'd2, 8'hF0);
    repeat (20) @(negedge clk);
    chk("ss_before_rst", ss_o, 4'hE);
    rst_n = 1'b0;
    #1;
    chk("midrst_sck", sck_o, 0);
    chk("midrst_ss", ss_o, 4'hF);
    chk("midrst_mosi", mosi_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk(3'd1, 8'h05, "stat_after_midrst");
    rd_chk(3'd0, 8'h00, "ctrl_after_midrst");
    rd_chk(3'd3, 8'h03, "div_after_midrst");
    rd_chk(3'd2, 8'h00, "no_rx_after_midrst");
    chk("scoreboard_empty", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_spi_master_mc.md
Name: wb_spi_master_mc

Overview:
- Parametrised successor to the single-channel Wishbone SPI master. It adds multiple chip selects, TX/RX FIFOs, all four CPOL/CPHA modes and a programmable SCK divider.
- Sits behind the I2C-to-Wishbone bridge as an 8-bit Wishbone slave.
- Drives one SPI bus shared by NCS slaves.

Parameters:
- NCS, 4, number of active-low chip-select outputs (1..8).
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, 2..16).
- DIV_RST, 8'h03, reset value of the DIV register.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- adr_i  in  3  register address.
- we_i  in  1  write enable.
- dat_i  in  8  write data.
- dat_o  out  8  read data.
- ack_o  out  1  bus acknowledge.
- inta_o  out  1  interrupt, active-high.
- sck_o  out  1  SPI clock.
- mosi_o  out  1  master out.
- miso_i  in  1  master in.
- ss_o  out  NCS  chip selects, active-low.

Behaviour:
- Reset (rst_i=0, async): all registers and FIFOs cleared; DIV=DIV_RST; outputs sck_o=0, mosi_o=0, ss_o=all 1, dat_o=0, ack_o=0, inta_o=0. Reset mid-transfer aborts immediately; no RX push.
- Bus handshake:
  - ack_o rises the cycle after cyc_i&stb_i&~ack_o and lasts exactly 1 cycle.
  - dat_o is valid with ack_o.
  - Register side effects occur on the ack cycle only, once per access.
- Register map:
  - 0 CTRL rw: [0]EN [1]CPOL [2]CPHA [3]IE, others read 0.
  - 1 STAT: [0]TXE [1]TXF [2]RXE [3]RXF [4]BUSY are ro; [5]RXOVF and [6]TXOVF are sticky, write-1-to-clear.
  - 2 DATA: write pushes TX FIFO; read pops RX FIFO.
  - 3 DIV rw: SCK half-period = DIV+1 clk cycles.
  - 4 CS rw: bits [NCS-1:0]; ss_o[i] = ~CS[i]. Unused bits read 0.
  - 5..7: reads return 0, writes ignored, still acked.
- FIFO boundaries:
  - DATA write with TX full: data dropped, TXOVF set.
  - DATA read with RX empty: returns 8'h00, no pop.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Engine FSM, IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - IDLE: sck_o=CPOL. Go to LOAD when EN=1 and TXE=0.
  - LOAD, 1 cycle:
    - Pop TX into shift register.
    - Latch CPOL, CPHA and DIV; changes to these mid-byte take effect on the next byte.
    - Bit counter=8, BUSY=1.
    - If CPHA=0, mosi_o = bit 7 now.
  - SHIFT: 16 half-periods, each DIV+1 cycles; sck_o toggles at the end of each half-period.
    - CPHA=0: sample miso_i on leading edges, shift/drive mosi on trailing edges.
    - CPHA=1: drive on leading edges, sample on trailing edges.
    - Data is MSB first.
  - DONE, 1 cycle:
    - Push received byte to RX FIFO. If RX is full, the byte is dropped and RXOVF set.
    - BUSY=0 in the following IDLE cycle unless TX is non-empty and EN=1, in which case go straight to LOAD; back-to-back bytes are separated by exactly one DONE cycle.
  - Latency: pop to RX push visible = 16*(DIV+1)+2 cycles.
  - Clearing EN mid-byte finishes the current byte, then the FSM idles.
- Chip selects: fully software-controlled and never toggled by the engine; a multi-byte frame holds CS across bytes.
- Interrupt: inta_o registered, = IE & (~RXE | RXOVF | TXOVF).
- Simultaneous events in the same cycle:
  - Bus push + engine pop on TX: both take effect.
  - Engine push + bus pop on RX with RX full: push succeeds, no overflow.
  - Write-1-clear + new overflow on the same bit: the set wins.

Test Plan:
- Reset, then read all registers -> CTRL=00, STAT=05 (TXE,RXE), DIV=03, CS=00; ss_o=all 1, sck_o=0.
- Mode 0, DIV=0, CS=01, EN=1, write A5, miso looped to mosi -> ss_o[0]=0, 8 SCK pulses of 1-cycle half-period, RX pop returns A5 exactly 18 cycles after LOAD, BUSY then clears.
- Modes 1/2/3 with the slave model returning 3C, write C3 -> slave captures C3, RX returns 3C; idle sck_o equals CPOL after each byte.
- FIFO_DEPTH=4: write 5 bytes with EN=0 -> TXF=1, TXOVF=1, 5th byte lost. Set EN with RX not read -> after 4 bytes RXF=1; a 5th transfer sets RXOVF and inta_o=1 when IE=1. Write 60 to STAT -> both clear.
- Change DIV from 0 to 7 mid-byte -> current byte keeps a 1-cycle half-period, next byte uses 8-cycle half-periods.
- Assert rst_i low in mid-SHIFT -> sck_o=0, ss_o=all 1, BUSY=0 immediately, no RX push, FIFOs empty.
